// File: rtl/ram_arbiter_if.sv
// Core-side request/response bundle plus the RAM control/data port of ram_arbiter.
// The arbiter takes the slave view; cores and RAM together form the master view.
interface ram_arbiter_if #(
   parameter int N_CORES    = 4,
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 8
);
   logic [N_CORES-1:0]            req;
   logic [N_CORES-1:0]            wrEn;
   logic [N_CORES*ADDR_WIDTH-1:0] addr;
   logic [N_CORES*DATA_WIDTH-1:0] wrData;
   logic [N_CORES-1:0]            done;
   logic [DATA_WIDTH-1:0]         rdData;
   logic [N_CORES-1:0]            grant;
   logic                          busy;
   logic                          ram_wrEn;
   logic [ADDR_WIDTH-1:0]         ram_address;
   logic [DATA_WIDTH-1:0]         ram_dataIn;
   logic [DATA_WIDTH-1:0]         ram_dataOut;

   modport master (
      output req, wrEn, addr, wrData, ram_dataOut,
      input  done, rdData, grant, busy, ram_wrEn, ram_address, ram_dataIn
   );

   modport slave (
      input  req, wrEn, addr, wrData, ram_dataOut,
      output done, rdData, grant, busy, ram_wrEn, ram_address, ram_dataIn
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous-read RAM between N_CORES cores.
// Each access runs IDLE -> ISSUE -> RESP; every output is driven from a register.
module ram_arbiter #(
   parameter int N_CORES    = 4,
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   ram_arbiter_if.slave  bus
);
   localparam int              PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam logic [PTR_W:0]  NC    = (PTR_W+1)'(N_CORES);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                 state, state_next;
   logic [PTR_W-1:0]       ptr, ptr_next, win_idx, win_off;
   logic [PTR_W:0]         win_sum, nxt_sum;
   logic                   win_vld;
   logic [N_CORES-1:0]     eligible, rot, win_oh;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   sel_wr;

   // A core whose done is high this cycle has just been served and must not win again.
   assign eligible = bus.req & ~bus.done;

   always_comb begin
      // Rotate so that bit 0 corresponds to ptr; the lowest set bit is the winner's offset.
      rot     = (eligible >> ptr) | (eligible << (N_CORES - int'(ptr)));
      win_vld = 1'b0;
      win_off = '0;
      for (int i = N_CORES-1; i >= 0; i--) begin
         if (rot[i]) begin
            win_vld = 1'b1;
            win_off = PTR_W'(i);
         end
      end

      win_sum = {1'b0, ptr} + {1'b0, win_off};
      if (win_sum >= NC) win_sum = win_sum - NC;
      win_idx = win_sum[PTR_W-1:0];

      nxt_sum = {1'b0, win_idx} + (PTR_W+1)'(1);
      if (nxt_sum >= NC) nxt_sum = nxt_sum - NC;
      ptr_next = nxt_sum[PTR_W-1:0];

      win_oh   = '0;
      sel_addr = '0;
      sel_data = '0;
      sel_wr   = 1'b0;
      for (int c = 0; c < N_CORES; c++) begin
         if (win_idx == PTR_W'(c)) begin
            win_oh[c] = win_vld;
            sel_addr  = bus.addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data  = bus.wrData[c*DATA_WIDTH +: DATA_WIDTH];
            sel_wr    = bus.wrEn[c];
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (win_vld) state_next = ISSUE;
         ISSUE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr             <= '0;
         bus.done        <= '0;
         bus.grant       <= '0;
         bus.busy        <= 1'b0;
         bus.ram_wrEn    <= 1'b0;
         bus.ram_address <= '0;
         bus.ram_dataIn  <= '0;
         bus.rdData      <= '0;
      end else begin
         bus.done <= '0;
         case (state)
            // Arbitration: latch the winner's request onto the RAM port.
            IDLE: begin
               if (win_vld) begin
                  bus.ram_address <= sel_addr;
                  bus.ram_dataIn  <= sel_data;
                  bus.ram_wrEn    <= sel_wr;
                  bus.grant       <= win_oh;
                  bus.busy        <= 1'b1;
                  ptr             <= ptr_next;
               end else begin
                  bus.ram_wrEn <= 1'b0;
               end
            end
            // RAM samples address/data/wrEn at the edge closing this state.
            ISSUE: begin
               bus.ram_wrEn <= 1'b0;
            end
            // RAM output is valid now; hand it back with a one-cycle done.
            RESP: begin
               bus.rdData <= bus.ram_dataOut;
               bus.done   <= bus.grant;
               bus.grant  <= '0;
               bus.busy   <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 256x12 read-before-write synchronous RAM model.
module tb_ram_arbiter;
   localparam int N  = 4;
   localparam int DW = 12;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_arbiter_if #(.N_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ram_arbiter #(.N_CORES(N), .DATA_WIDTH(DW), .DEPTH(256), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] mem [0:255];
   always @(posedge clk) begin
      bus.ram_dataOut <= mem[bus.ram_address];
      if (bus.ram_wrEn) mem[bus.ram_address] <= bus.ram_dataIn;
   end

   int checks = 0;
   int errors = 0;
   int wr_cycles = 0;
   int run = 0;
   int max_run = 0;
   int done_pulses = 0;

   always @(negedge clk) begin
      if (bus.ram_wrEn) begin
         wr_cycles = wr_cycles + 1;
         run = run + 1;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (bus.done != '0) done_pulses = done_pulses + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req[c]            = 1'b1;
      bus.wrEn[c]           = we;
      bus.addr[c*AW +: AW]  = a;
      bus.wrData[c*DW +: DW] = d;
   endtask

   task automatic clr_req(input int c);
      bus.req[c] = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.done == '0 && n < 30);
      chk("done_seen", {31'b0, bus.done != '0}, 32'd1);
   endtask

   int n;
   int w0;
   int pulses_before;
   int rejoin;

   initial begin
      bus.req    = '0;
      bus.wrEn   = '0;
      bus.addr   = '0;
      bus.wrData = '0;

      // Reset values
      tick();
      tick();
      chk("rst_done",    bus.done, 0);
      chk("rst_grant",   bus.grant, 0);
      chk("rst_busy",    bus.busy, 0);
      chk("rst_wren",    bus.ram_wrEn, 0);
      chk("rst_addr",    bus.ram_address, 0);
      chk("rst_datain",  bus.ram_dataIn, 0);
      chk("rst_rddata",  bus.rdData, 0);
      rst = 1'b0;
      tick();

      // Seed 0x10 with 0x123, then abort a write of 0xABC there with reset in ISSUE
      set_req(0, 1'b1, 8'h10, 12'h123);
      wait_done(n);
      chk("seed_lat", n, 3);
      clr_req(0);
      tick();
      set_req(0, 1'b1, 8'h10, 12'hABC);
      tick();
      chk("iss_wren",  bus.ram_wrEn, 1);
      chk("iss_busy",  bus.busy, 1);
      chk("iss_grant", bus.grant, 4'b0001);
      chk("iss_addr",  bus.ram_address, 8'h10);
      chk("iss_data",  bus.ram_dataIn, 12'hABC);
      pulses_before = done_pulses;
      #1 rst = 1'b1;
      #1;
      chk("arst_done",  bus.done, 0);
      chk("arst_grant", bus.grant, 0);
      chk("arst_busy",  bus.busy, 0);
      chk("arst_wren",  bus.ram_wrEn, 0);
      clr_req(0);
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("no_done_after_rst", done_pulses - pulses_before, 0);
      chk("idle_after_rst", bus.busy, 0);

      // ptr back at 0: core 0 beats core 1; aborted write left 0x123 in place
      set_req(0, 1'b0, 8'h10, 12'h000);
      set_req(1, 1'b0, 8'h10, 12'h000);
      tick();
      chk("ptr0_grant", bus.grant, 4'b0001);
      tick();
      tick();
      chk("ptr0_done", bus.done, 4'b0001);
      chk("abort_no_commit", bus.rdData, 12'h123);
      clr_req(0);
      tick();
      chk("next_grant1", bus.grant, 4'b0010);
      tick();
      tick();
      chk("done1", bus.done, 4'b0010);
      chk("rd1", bus.rdData, 12'h123);
      clr_req(1);
      tick();

      // Core 2 write then read of 0x3F
      w0 = wr_cycles;
      set_req(2, 1'b1, 8'h3F, 12'h5A5);
      wait_done(n);
      chk("w2_lat", n, 3);
      chk("w2_done", bus.done, 4'b0100);
      clr_req(2);
      tick();
      chk("w2_wren_cycles", wr_cycles - w0, 1);
      w0 = wr_cycles;
      set_req(2, 1'b0, 8'h3F, 12'h000);
      wait_done(n);
      chk("r2_lat", n, 3);
      chk("r2_done", bus.done, 4'b0100);
      chk("r2_data", bus.rdData, 12'h5A5);
      clr_req(2);
      tick();
      chk("r2_no_wren", wr_cycles - w0, 0);

      // Read-before-write at 0x01
      set_req(0, 1'b1, 8'h01, 12'h111);
      wait_done(n);
      clr_req(0);
      tick();
      set_req(0, 1'b1, 8'h01, 12'h222);
      wait_done(n);
      chk("rbw_old", bus.rdData, 12'h111);
      clr_req(0);
      tick();
      set_req(0, 1'b0, 8'h01, 12'h000);
      wait_done(n);
      chk("rbw_new", bus.rdData, 12'h222);
      clr_req(0);
      tick();

      // Core 3 writes the top address; ptr wraps 3 -> 0
      set_req(3, 1'b1, 8'hFF, 12'hFFF);
      wait_done(n);
      chk("top_w_done", bus.done, 4'b1000);
      clr_req(3);
      tick();

      // Round robin with all cores requesting
      w0 = wr_cycles;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h80 + i), 12'(12'h700 + i));
      rejoin = -1;
      for (int k = 0; k < 8; k++) begin
         n = 0;
         do begin
            tick();
            n++;
            if (rejoin >= 0) begin
               set_req(rejoin, 1'b1, 8'(8'h80 + rejoin), 12'(12'h700 + rejoin));
               rejoin = -1;
            end
         end while (bus.done == '0 && n < 12);
         chk("rr_order", bus.done, 32'(1 << (k % 4)));
         chk("rr_gap", n, 3);
         clr_req(k % 4);
         rejoin = (k < 4) ? (k % 4) : -1;
      end
      tick();
      chk("rr_wren_cycles", wr_cycles - w0, 8);
      chk("rr_wren_width", max_run, 1);

      // Core 0 reads back the top address
      set_req(0, 1'b0, 8'hFF, 12'h000);
      wait_done(n);
      chk("top_r_done", bus.done, 4'b0001);
      chk("top_r_data", bus.rdData, 12'hFFF);
      clr_req(0);
      tick();

      // Held req on core 1, alone
      set_req(1, 1'b0, 8'h3F, 12'h000);
      wait_done(n);
      chk("held_done1", bus.done, 4'b0010);
      tick();
      chk("held_no_grant", bus.grant, 0);
      chk("held_idle", bus.busy, 0);
      tick();
      chk("held_regrant", bus.grant, 4'b0010);
      tick();
      tick();
      chk("held_done2", bus.done, 4'b0010);
      chk("held_data2", bus.rdData, 12'h5A5);
      clr_req(1);
      tick();

      // Held req on core 1 while core 2 requests: core 2 wins first
      set_req(1, 1'b0, 8'h01, 12'h000);
      wait_done(n);
      chk("hp_done1", bus.done, 4'b0010);
      set_req(2, 1'b0, 8'h01, 12'h000);
      tick();
      chk("hp_grant2", bus.grant, 4'b0100);
      tick();
      tick();
      chk("hp_done2", bus.done, 4'b0100);
      chk("hp_data2", bus.rdData, 12'h222);
      clr_req(2);
      tick();
      tick();
      tick();
      chk("hp_done1b", bus.done, 4'b0010);
      chk("hp_data1b", bus.rdData, 12'h222);
      clr_req(1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares one single-port, synchronous-read data RAM (12-bit words, 256 deep, one-cycle read latency, read-before-write) between N_CORES processor cores. It sits between the cores' memory request ports and the RAM's clk/wrEn/dataIn/address/dataOut port. It serialises accesses, drives the RAM control signals from registers, and returns read data with a one-hot completion pulse to the winning core.

## Interface
- N_CORES, 4, number of requesting cores (2..8)
- DATA_WIDTH, 12, RAM word width
- DEPTH, 256, RAM depth in words
- ADDR_WIDTH, $clog2(DEPTH), RAM address width

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N_CORES  per-core access request, held until matching done
- wrEn  input  N_CORES  per-core write (1) / read (0), stable while req high
- addr  input  N_CORES*ADDR_WIDTH  per-core address, core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- wrData  input  N_CORES*DATA_WIDTH  per-core write data, same packing
- done  output  N_CORES  one-hot, one-cycle completion pulse
- rdData  output  DATA_WIDTH  RAM word for the completed access, valid while done != 0, held otherwise
- grant  output  N_CORES  one-hot owner of the in-flight access, 0 when idle
- busy  output  1  access in flight (state != IDLE)
- ram_wrEn  output  1  to RAM wrEn
- ram_address  output  ADDR_WIDTH  to RAM address
- ram_dataIn  output  DATA_WIDTH  to RAM dataIn
- ram_dataOut  input  DATA_WIDTH  from RAM dataOut

## Operation
- States: IDLE, ISSUE, RESP. All outputs come from registers.
- IDLE:
  - Eligible set = req & ~done. A core whose done is high this cycle is ignored.
  - If the eligible set is non-empty, the winner is the first eligible index scanning upward from ptr, modulo N_CORES.
  - At the clock edge: latch the winner's addr/wrData/wrEn into ram_address/ram_dataIn/ram_wrEn; set grant to the winner's one-hot; set ptr to (winner+1) mod N_CORES; go to ISSUE.
  - If nothing is eligible: stay in IDLE, ram_wrEn=0.
- ISSUE: the RAM samples its inputs at the closing edge. At that edge, clear ram_wrEn and go to RESP.
- RESP:
  - ram_dataOut is valid this cycle.
  - At the closing edge: rdData <= ram_dataOut; done <= grant; grant <= 0; go to IDLE.
- done is cleared at the next edge, so it is exactly one cycle wide.
- Writes also produce done. Their rdData is the pre-write contents of the address (read-before-write).
- ram_wrEn is high for exactly one cycle per write (ISSUE only), and never during IDLE or RESP.
- ram_address and ram_dataIn hold their last values when idle.
- Core obligation: deassert req in the cycle done is high. If req is still high the following cycle, that is a new request.
- Reset values:
  - state=IDLE, ptr=0
  - done=0, grant=0, busy=0
  - ram_wrEn=0, ram_address=0, ram_dataIn=0, rdData=0
- Reset mid-operation: the in-flight access is abandoned and no done is issued. A write in ISSUE commits only if rst is low at the ISSUE-closing edge. The core must re-request after reset.

## Timing
- Request sampled high in IDLE cycle C0 -> ISSUE in C1 -> RESP in C2 -> done and rdData in C3.
- Fixed latency is 3 cycles from the first eligible sample to done.
- Throughput: one access per 3 cycles. With back-to-back requests, the next grant is decided in the done cycle (C3) and its ISSUE is C4.
- Requests arriving while busy wait; none are lost, and none are granted before the current access completes.
- Fairness: with all cores requesting continuously, grants rotate 0,1,...,N_CORES-1,0. Worst-case wait is (N_CORES-1) accesses, i.e. 3*(N_CORES-1)+3 cycles to done.
- busy = (state != IDLE), high in ISSUE and RESP.

## Test plan
- Reset: assert rst mid-ISSUE of a write of 0xABC to address 0x10 -> done, grant, busy and ram_wrEn go to 0 immediately; no done pulse follows; after release ptr=0 and the arbiter is IDLE.
- Single write then read: core 2 writes 0x5A5 to address 0x3F; done[2] arrives 3 cycles after req. Core 2 then reads 0x3F -> done[2] with rdData=0x5A5, and ram_wrEn stays 0 for the read.
- Read-before-write: address 0x01 holds 0x111; core 0 writes 0x222 to it -> rdData=0x111 with done[0]; a following read returns 0x222.
- Round robin: all 4 cores request continuously, each core releasing req on its done and re-requesting the next cycle -> done order 0,1,2,3,0,1,2,3; done pulses 3 cycles apart; each ram_wrEn pulse is 1 cycle wide.
- Held req: core 1 keeps req high for one extra cycle after done[1] -> no grant in the done cycle; a second access for core 1 is granted the following cycle, unless core 2 or 3 is requesting, in which case the higher-priority core (2 first) is granted.
- Boundary: core 3 accesses address 0xFF (DEPTH-1) with data 0xFFF, then core 0 reads it -> rdData=0xFFF; ptr wraps from 3 to 0.
